// File: rtl/latch_capture_arbiter_if.sv
// latch_capture_arbiter_if
// Bundles the requester-side bus of the capture arbiter.
//   reqIn     : per-requester request level
//   dataIn    : requester words, requester i at [i*DATA_W +: DATA_W]
//   grantOut  : one-hot grant (zero when idle)
//   doneOut   : one-cycle completion pulse to the granted requester
//   latchData : word driven to the shared latch data input
//   crit      : latch gate, 0 = transparent, 1 = opaque
//   busy      : arbiter is not idle
// Modports: master = requester/latch side, slave = the arbiter.
interface latch_capture_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        reqIn;
    logic [N_REQ*DATA_W-1:0] dataIn;
    logic [N_REQ-1:0]        grantOut;
    logic [N_REQ-1:0]        doneOut;
    logic [DATA_W-1:0]       latchData;
    logic                    crit;
    logic                    busy;

    modport master (
        output reqIn, dataIn,
        input  grantOut, doneOut, latchData, crit, busy
    );

    modport slave (
        input  reqIn, dataIn,
        output grantOut, doneOut, latchData, crit, busy
    );
endinterface

// File: rtl/latch_capture_arbiter.sv
// latch_capture_arbiter
// Round-robin arbiter that shares one transparent-low capture latch among
// N_REQ requesters. The winner's word is registered onto latchData, then
// crit is opened (driven low) for exactly HOLD_CYC cycles and closed again,
// after which doneOut pulses to the winner.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : latch_capture_arbiter_if.slave (reqIn/dataIn in; grantOut,
//         doneOut, latchData, crit, busy out -- all registered)
module latch_capture_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    latch_capture_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} state_t;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]   gidx_reg, gidx_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic               crit_reg, crit_next;
    logic               busy_reg;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [3:0]         cnt_reg, cnt_next;

    // Per-requester view of the flat data bus.
    logic [DATA_W-1:0]  words [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_words
            assign words[gi] = bus.dataIn[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Pointer value that follows the current grant.
    logic [IDX_W-1:0] ptr_after_g;
    assign ptr_after_g = (gidx_reg == IDX_W'(N_REQ - 1)) ? '0 : gidx_reg + IDX_W'(1);

    // Round-robin search. In CLOSE the current winner is masked since it may
    // still be holding its request, and the search starts just past it.
    logic [N_REQ-1:0] arb_req;
    logic [IDX_W-1:0] arb_start;
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [N_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0] pos_idx;
    int               pos;

    always_comb begin
        arb_req   = bus.reqIn;
        arb_start = ptr_reg;
        if (state_reg == CLOSE) begin
            arb_req   = bus.reqIn & ~grant_reg;
            arb_start = ptr_after_g;
        end
        arb_found = 1'b0;
        arb_idx   = '0;
        pos       = 0;
        pos_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(arb_start) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = IDX_W'(pos);
            if (!arb_found && arb_req[pos_idx]) begin
                arb_found = 1'b1;
                arb_idx   = pos_idx;
            end
        end
        arb_onehot          = '0;
        arb_onehot[arb_idx] = 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        gidx_next  = gidx_reg;
        done_next  = '0;
        data_next  = data_reg;
        crit_next  = 1'b1;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    state_next = SETUP;
                    grant_next = arb_onehot;
                    gidx_next  = arb_idx;
                    data_next  = words[arb_idx];
                end
            end
            SETUP: begin
                state_next = OPEN;
                crit_next  = 1'b0;
                cnt_next   = 4'(HOLD_CYC - 1);
            end
            OPEN: begin
                if (cnt_reg == 4'd0) begin
                    state_next = CLOSE;
                    done_next  = grant_reg;
                end else begin
                    cnt_next  = cnt_reg - 4'd1;
                    crit_next = 1'b0;
                end
            end
            CLOSE: begin
                ptr_next = ptr_after_g;
                if (arb_found) begin
                    state_next = SETUP;
                    grant_next = arb_onehot;
                    gidx_next  = arb_idx;
                    data_next  = words[arb_idx];
                end else begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            gidx_reg  <= '0;
            done_reg  <= '0;
            data_reg  <= '0;
            crit_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            gidx_reg  <= gidx_next;
            done_reg  <= done_next;
            data_reg  <= data_next;
            crit_reg  <= crit_next;
            busy_reg  <= (state_next != IDLE);
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.grantOut  = grant_reg;
    assign bus.doneOut   = done_reg;
    assign bus.latchData = data_reg;
    assign bus.crit      = crit_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_latch_capture_arbiter.sv
// tb_latch_capture_arbiter
// Directed bench: dut_a (HOLD_CYC=2) runs a per-cycle vector table for
// round-robin contention and a single capture, then hand sequences for data
// change during OPEN, request drop and asynchronous reset. dut_b
// (HOLD_CYC=4) covers reset in the middle of the open window.
module tb_latch_capture_arbiter;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    latch_capture_arbiter_if #(.N_REQ(4), .DATA_W(8)) ifa ();
    latch_capture_arbiter_if #(.N_REQ(4), .DATA_W(8)) ifb ();

    latch_capture_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    latch_capture_arbiter #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [3:0] done;
        logic [7:0] latch;
        logic       crit;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // Reset image of {grant, done, latch, crit, busy}: only crit is high.
    localparam logic [31:0] RESET_OUTS = 32'h0000_0002;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic [3:0] grant, input logic [3:0] done,
                       input logic [7:0] latch, input logic crit, input logic busy);
        vec_t v;
        v.req   = req;
        v.grant = grant;
        v.done  = done;
        v.latch = latch;
        v.crit  = crit;
        v.busy  = busy;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] outs_a();
        return {14'd0, ifa.grantOut, ifa.doneOut, ifa.latchData, ifa.crit, ifa.busy};
    endfunction

    function automatic logic [31:0] outs_b();
        return {14'd0, ifb.grantOut, ifb.doneOut, ifb.latchData, ifb.crit, ifb.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] done_or;

    initial begin
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        ifa.reqIn  = 4'b0000;
        ifa.dataIn = 32'h773C_11A5;
        ifb.reqIn  = 4'b0000;
        ifb.dataIn = 32'h0000_0000;

        repeat (2) tick();
        chk("reset_state_a", outs_a(), RESET_OUTS);
        @(negedge clk);
        rst_a = 1'b0;

        // req, grant, done, latch, crit, busy -- outputs just after each edge
        // Round robin 0,1,2,3,0; each requester drops on the cycle of its done.
        add(4'b1111, 4'b0001, 4'b0000, 8'hA5, 1'b1, 1'b1);
        add(4'b1111, 4'b0001, 4'b0000, 8'hA5, 1'b0, 1'b1);
        add(4'b1111, 4'b0001, 4'b0000, 8'hA5, 1'b0, 1'b1);
        add(4'b1111, 4'b0001, 4'b0001, 8'hA5, 1'b1, 1'b1);
        add(4'b1110, 4'b0010, 4'b0000, 8'h11, 1'b1, 1'b1);
        add(4'b1111, 4'b0010, 4'b0000, 8'h11, 1'b0, 1'b1);
        add(4'b1111, 4'b0010, 4'b0000, 8'h11, 1'b0, 1'b1);
        add(4'b1111, 4'b0010, 4'b0010, 8'h11, 1'b1, 1'b1);
        add(4'b1101, 4'b0100, 4'b0000, 8'h3C, 1'b1, 1'b1);
        add(4'b1111, 4'b0100, 4'b0000, 8'h3C, 1'b0, 1'b1);
        add(4'b1111, 4'b0100, 4'b0000, 8'h3C, 1'b0, 1'b1);
        add(4'b1111, 4'b0100, 4'b0100, 8'h3C, 1'b1, 1'b1);
        add(4'b1011, 4'b1000, 4'b0000, 8'h77, 1'b1, 1'b1);
        add(4'b1111, 4'b1000, 4'b0000, 8'h77, 1'b0, 1'b1);
        add(4'b1111, 4'b1000, 4'b0000, 8'h77, 1'b0, 1'b1);
        add(4'b1111, 4'b1000, 4'b1000, 8'h77, 1'b1, 1'b1);
        add(4'b0111, 4'b0001, 4'b0000, 8'hA5, 1'b1, 1'b1);
        add(4'b0000, 4'b0001, 4'b0000, 8'hA5, 1'b0, 1'b1);
        add(4'b0000, 4'b0001, 4'b0000, 8'hA5, 1'b0, 1'b1);
        add(4'b0000, 4'b0001, 4'b0001, 8'hA5, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0);
        // Single capture from requester 0 (pointer now 1, wraps to 0).
        add(4'b0001, 4'b0001, 4'b0000, 8'hA5, 1'b1, 1'b1);
        add(4'b0000, 4'b0001, 4'b0000, 8'hA5, 1'b0, 1'b1);
        add(4'b0000, 4'b0001, 4'b0000, 8'hA5, 1'b0, 1'b1);
        add(4'b0000, 4'b0001, 4'b0001, 8'hA5, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            ifa.reqIn = vecs[i].req;
            tick();
            chk($sformatf("vec%0d", i), outs_a(),
                {14'd0, vecs[i].grant, vecs[i].done, vecs[i].latch, vecs[i].crit, vecs[i].busy});
        end

        // Data change during OPEN: requester 2 word 3C -> FF must not leak.
        ifa.reqIn = 4'b0100;
        tick();
        chk("dchg_grant", {28'd0, ifa.grantOut}, 32'h4);
        chk("dchg_latch_setup", {24'd0, ifa.latchData}, 32'h3C);
        ifa.reqIn = 4'b0000;
        tick();
        chk("dchg_crit_open", {31'd0, ifa.crit}, 32'h0);
        ifa.dataIn[23:16] = 8'hFF;
        tick();
        chk("dchg_latch_open", {24'd0, ifa.latchData}, 32'h3C);
        tick();
        chk("dchg_done", {28'd0, ifa.doneOut}, 32'h4);
        chk("dchg_latch_close", {24'd0, ifa.latchData}, 32'h3C);
        tick();
        chk("dchg_idle", {31'd0, ifa.busy}, 32'h0);

        // Request drop in SETUP: transaction still completes.
        ifa.reqIn = 4'b0010;
        tick();
        chk("drop_grant", {28'd0, ifa.grantOut}, 32'h2);
        ifa.reqIn = 4'b0000;
        tick();
        tick();
        tick();
        chk("drop_done", {28'd0, ifa.doneOut, 3'd0, ifa.crit}, 32'h21);
        tick();
        chk("drop_idle", outs_a(), {14'd0, 4'b0000, 4'b0000, 8'h11, 1'b1, 1'b0});

        // Asynchronous reset mid-cycle, no clock edge in between.
        ifa.reqIn = 4'b0001;
        tick();
        chk("areset_pre_busy", {31'd0, ifa.busy}, 32'h1);
        #2 rst_a = 1'b1;
        #1;
        chk("areset_outs", outs_a(), RESET_OUTS);
        @(negedge clk);
        rst_a     = 1'b0;
        ifa.reqIn = 4'b0000;

        // Reset in the second OPEN cycle with HOLD_CYC=4.
        rst_b      = 1'b0;
        ifb.reqIn  = 4'b0110;
        ifb.dataIn = 32'h00C3_5A00;
        tick();
        chk("b_grant", {28'd0, ifb.grantOut}, 32'h2);
        chk("b_latch", {24'd0, ifb.latchData}, 32'h5A);
        tick();
        chk("b_open1_crit", {31'd0, ifb.crit}, 32'h0);
        tick();
        chk("b_open2_crit", {31'd0, ifb.crit}, 32'h0);
        #2 rst_b = 1'b1;
        #1;
        chk("b_reset_outs", outs_b(), RESET_OUTS);
        ifb.reqIn = 4'b0100;
        @(negedge clk);
        rst_b = 1'b0;
        tick();
        chk("b_regrant", {28'd0, ifb.grantOut, ifb.doneOut}, 32'h40);
        chk("b_regrant_latch", {24'd0, ifb.latchData}, 32'hC3);
        ifb.reqIn = 4'b0000;
        done_or   = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            tick();
            done_or = done_or | ifb.doneOut;
        end
        chk("b_done_only_new", {28'd0, done_or}, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
